// File: rtl/xrv_ifu.sv
// xrv_ifu: sequential instruction fetch over a req/gnt + rvalid port with an in-order
// DEPTH-entry instruction queue; jump/flush redirects and drops every pending response.
module xrv_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        stalling,
  input  logic        flush,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic          active_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   mem_q [DEPTH];

  logic          redirect;
  logic          credit_ok;
  logic          issue;
  logic          rv;
  logic          drop;
  logic          push;
  logic          pop;
  logic [31:0]   target;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^jmp_addr[1:0];

  assign imem_addr = fetch_pc_q;
  assign if_valid  = (count_q != '0);
  assign if_instr  = mem_q[rd_ptr_q];
  assign if_pc     = head_pc_q;

  // Credit check, handshake qualification and next-state computation
  always_comb begin
    redirect  = jmp | flush;
    credit_ok = (SW'(outstanding_q) + SW'(count_q)) < SW'(DEPTH);
    imem_req  = active_q & credit_ok & ~redirect;
    issue     = imem_req & imem_gnt;
    rv        = imem_rvalid & (outstanding_q != '0);
    drop      = rv & (discard_q != '0);
    push      = rv & (discard_q == '0) & ~redirect;
    pop       = (count_q != '0) & ~stalling & ~redirect;
    target    = jmp ? {jmp_addr[31:2], 2'b00} : head_pc_q;

    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(rv);
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect) begin
      // Everything still pending after this cycle belongs to the old stream
      fetch_pc_d = target;
      head_pc_d  = target;
      discard_d  = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        head_pc_d = head_pc_q + 32'd4;
        rd_ptr_d  = rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (drop) begin
        discard_d = discard_q - CW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      active_q      <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Instruction queue storage
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_xrv_ifu.sv
// tb_xrv_ifu: directed scenarios for xrv_ifu against a fixed-latency in-order
// memory model returning addr ^ 32'hA5A5_0000.
module tb_xrv_ifu;

  logic        clk = 1'b0;
  logic        rstb;
  logic        stalling;
  logic        flush;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic        gnt_en;
  logic        inject;
  int          mem_lat;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en;

  xrv_ifu dut (
    .clk        (clk),
    .rstb       (rstb),
    .stalling   (stalling),
    .flush      (flush),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  // Memory: accepted request at cycle c answers with rvalid sampled at edge c+mem_lat
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + mem_lat});
      if (inject) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= 32'hDEAD_BEEF;
      end else if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= pend[0].addr ^ KEY;
        void'(pend.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic wait_pop(input int budget, output logic [31:0] pc, output logic [31:0] ins,
                          output int waited, output bit ok);
    ok = 1'b0; pc = '0; ins = '0; waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk); #1;
      if (if_valid && !stalling && !jmp && !flush) begin
        pc = if_pc; ins = if_instr; waited = i; ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; stalling = 1'b0; flush = 1'b0; jmp = 1'b0; jmp_addr = '0;
    gnt_en = 1'b1; mem_lat = 1; inject = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
    n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", if_instr); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", if_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] pc, ins;
    int w;
    bit ok;
    @(negedge clk); rstb = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL release_req got %b want 0", imem_req); end
    for (int k = 0; k < 6; k++) begin
      wait_pop(20, pc, ins, w, ok);
      n_cmp++;
      if (!ok || pc !== 32'(4 * k) || ins !== (32'(4 * k) ^ KEY)) begin
        n_fail++; $display("FAIL stream_%0d got ok=%b pc=%h instr=%h want pc=%h instr=%h", k, ok, pc, ins, 32'(4 * k), 32'(4 * k) ^ KEY);
      end
      if (k == 0) begin
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL first_latency got %0d want 3", w); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc, ins;
    int w;
    bit ok;
    @(negedge clk); stalling = 1'b1; #1;
    for (int i = 0; i < 5 && !if_valid; i++) begin @(negedge clk); #1; end
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h18) begin n_fail++; $display("FAIL stall_head got v=%b pc=%h want v=1 pc=00000018", if_valid, if_pc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (if_pc !== 32'h18 || if_instr !== (32'h18 ^ KEY)) begin
        n_fail++; $display("FAIL stall_hold_%0d got pc=%h instr=%h want pc=00000018 instr=%h", i, if_pc, if_instr, 32'h18 ^ KEY);
      end
    end
    n_cmp++; if (imem_req !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_full got req=%b v=%b want req=0 v=1", imem_req, if_valid); end
    @(negedge clk); stalling = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h18) begin n_fail++; $display("FAIL stall_release got v=%b pc=%h want v=1 pc=00000018", if_valid, if_pc); end
    for (int k = 1; k < 3; k++) begin
      wait_pop(10, pc, ins, w, ok);
      n_cmp++;
      if (!ok || pc !== 32'(32'h18 + 4 * k) || ins !== (32'(32'h18 + 4 * k) ^ KEY)) begin
        n_fail++; $display("FAIL resume_%0d got ok=%b pc=%h instr=%h want pc=%h", k, ok, pc, ins, 32'(32'h18 + 4 * k));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] pc, ins;
    int w;
    bit ok, found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk); #1;
      if (if_valid && if_pc == 32'h40) begin stalling = 1'b1; found = 1'b1; end
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL flush_reach got found=%b want 1", found); end
    repeat (3) @(negedge clk);
    @(negedge clk); flush = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL flush_req got %b want 0", imem_req); end
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++; $display("FAIL flush_refetch got v=%b req=%b addr=%h want v=0 req=1 addr=00000040", if_valid, imem_req, imem_addr);
    end
    stalling = 1'b0;
    wait_pop(10, pc, ins, w, ok);
    n_cmp++; if (!ok || pc !== 32'h40 || ins !== (32'h40 ^ KEY)) begin n_fail++; $display("FAIL flush_redeliver got ok=%b pc=%h instr=%h want pc=00000040", ok, pc, ins); end
    wait_pop(10, pc, ins, w, ok);
    n_cmp++; if (!ok || pc !== 32'h44 || ins !== (32'h44 ^ KEY)) begin n_fail++; $display("FAIL flush_next got ok=%b pc=%h instr=%h want pc=00000044", ok, pc, ins); end
  endtask

  task automatic test_jump_inflight();
    logic [31:0] pc, ins;
    int w;
    bit ok;
    @(negedge clk); rstb = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL midop_reset got v=%b pc=%h req=%b want 0/0/0", if_valid, if_pc, imem_req); end
    mem_lat = 3;
    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL jmp_second_req got req=%b addr=%h want req=1 addr=00000004", imem_req, imem_addr); end
    @(negedge clk); jmp = 1'b1; jmp_addr = 32'h0000_0103; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL jmp_req got %b want 0", imem_req); end
    @(negedge clk); jmp = 1'b0; #1;
    n_cmp++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_target got addr=%h v=%b want addr=00000100 v=0", imem_addr, if_valid); end
    wait_pop(30, pc, ins, w, ok);
    n_cmp++; if (!ok || pc !== 32'h100 || ins !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL jmp_first got ok=%b pc=%h instr=%h want pc=00000100 instr=%h", ok, pc, ins, 32'h100 ^ KEY); end
    wait_pop(30, pc, ins, w, ok);
    n_cmp++; if (!ok || pc !== 32'h104 || ins !== (32'h104 ^ KEY)) begin n_fail++; $display("FAIL jmp_second got ok=%b pc=%h instr=%h want pc=00000104", ok, pc, ins); end
  endtask

  task automatic test_gnt_wait();
    logic [31:0] pc, ins;
    int w;
    bit ok;
    @(negedge clk); rstb = 1'b0; gnt_en = 1'b0; mem_lat = 1;
    @(negedge clk); rstb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL gnt_hold_%0d got req=%b addr=%h want req=1 addr=0", i, imem_req, imem_addr); end
    end
    @(negedge clk); jmp = 1'b1; jmp_addr = 32'h0000_0200; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL gnt_jmp_req got %b want 0", imem_req); end
    @(negedge clk); jmp = 1'b0; gnt_en = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL gnt_jmp_target got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
    wait_pop(10, pc, ins, w, ok);
    n_cmp++; if (!ok || pc !== 32'h200 || ins !== (32'h200 ^ KEY)) begin n_fail++; $display("FAIL gnt_first got ok=%b pc=%h instr=%h want pc=00000200", ok, pc, ins); end
  endtask

  task automatic test_wrap_spurious();
    logic [31:0] pc, ins;
    logic [31:0] exp_pc [4];
    int w;
    bit ok;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    @(negedge clk); jmp = 1'b1; jmp_addr = 32'hFFFF_FFFA;
    @(negedge clk); jmp = 1'b0; #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_target got %h want fffffff8", imem_addr); end
    for (int k = 0; k < 4; k++) begin
      wait_pop(10, pc, ins, w, ok);
      n_cmp++;
      if (!ok || pc !== exp_pc[k] || ins !== (exp_pc[k] ^ KEY)) begin
        n_fail++; $display("FAIL wrap_%0d got ok=%b pc=%h instr=%h want pc=%h instr=%h", k, ok, pc, ins, exp_pc[k], exp_pc[k] ^ KEY);
      end
    end
    @(negedge clk); stalling = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || imem_req !== 1'b0) begin n_fail++; $display("FAIL spur_pre got v=%b pc=%h req=%b want v=1 pc=00000008 req=0", if_valid, if_pc, imem_req); end
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== (32'h8 ^ KEY) || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL spur_ignored got v=%b pc=%h instr=%h req=%b want v=1 pc=00000008 instr=%h req=0", if_valid, if_pc, if_instr, imem_req, 32'h8 ^ KEY);
    end
    @(negedge clk); stalling = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin n_fail++; $display("FAIL spur_release got v=%b pc=%h want v=1 pc=00000008", if_valid, if_pc); end
    wait_pop(10, pc, ins, w, ok);
    n_cmp++; if (!ok || pc !== 32'hC || ins !== (32'hC ^ KEY)) begin n_fail++; $display("FAIL spur_next got ok=%b pc=%h instr=%h want pc=0000000c instr=%h", ok, pc, ins, 32'hC ^ KEY); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_jump_inflight();
    test_gnt_wait();
    test_wrap_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
